fp32_adder: RTL and testbench



---
 rtl/fp32_adder.sv | 89 ++++++++
 tb/tb_fp32_adder.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/fp32_adder.sv
// fp32_adder: tagged-format FP32 adder with round-to-nearest-even and a registered result.
// FP32_ADDER_INPUT_REG_EN adds an operand register stage, making the latency 2 cycles.
module fp32_adder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [33:0] X,
  input  logic [33:0] Y,
  output logic [33:0] R,
  output logic        out_valid
);
  logic [33:0] w_x, w_y, w_norm, w_res, r_r;
  logic [31:0] w_a, w_b;
  logic [1:0]  w_xe, w_ye;
  logic        w_v, r_v, w_swap, w_up;
  logic [7:0]  w_d;
  logic [26:0] w_asig, w_bsig, w_bsh, w_m;
  logic [27:0] w_sum;
  logic [4:0]  w_lz;
  logic [24:0] w_rnd;
  logic signed [9:0] w_e, w_ef;
`ifdef FP32_ADDER_INPUT_REG_EN
  logic [33:0] r_x, r_y;
  logic        r_iv;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x  <= 34'd0;
      r_y  <= 34'd0;
      r_iv <= 1'b0;
    end else begin
      r_x  <= X;
      r_y  <= Y;
      r_iv <= in_valid;
    end
  end
  assign w_x = r_x;
  assign w_y = r_y;
  assign w_v = r_iv;
`else
  assign w_x = X;
  assign w_y = Y;
  assign w_v = in_valid;
`endif
  assign w_xe   = w_x[33:32];
  assign w_ye   = w_y[33:32];
  assign w_swap = w_y[30:0] > w_x[30:0];
  assign w_a    = w_swap ? w_y[31:0] : w_x[31:0];
  assign w_b    = w_swap ? w_x[31:0] : w_y[31:0];
  assign w_d    = w_a[30:23] - w_b[30:23];
  assign w_asig = {1'b1, w_a[22:0], 3'b000};
  assign w_bsig = {1'b1, w_b[22:0], 3'b000};
  // Bits shifted past the round position fold into the sticky bit.
  assign w_bsh  = (w_d >= 8'd26) ? 27'd1 :
                  (w_bsig >> w_d) | {26'd0, |(w_bsig & ~(27'h7ffffff << w_d))};
  assign w_sum  = (w_a[31] == w_b[31]) ? {1'b0, w_asig} + {1'b0, w_bsh}
                                       : {1'b0, w_asig} - {1'b0, w_bsh};
  always_comb begin
    w_lz = 5'd0;
    for (int i = 0; i < 27; i++) if (w_sum[i]) w_lz = 5'(26 - i);
  end
  assign w_m   = w_sum[27] ? {w_sum[27:2], w_sum[1] | w_sum[0]} : w_sum[26:0] << w_lz;
  assign w_e   = w_sum[27] ? $signed({2'b00, w_a[30:23]}) + 10'sd1
                           : $signed({2'b00, w_a[30:23]}) - $signed({5'd0, w_lz});
  assign w_up  = w_m[2] & (w_m[1] | w_m[0] | w_m[3]);
  assign w_rnd = {1'b0, w_m[26:3]} + {24'd0, w_up};
  assign w_ef  = w_e + $signed({9'd0, w_rnd[24]});
  assign w_norm = (w_sum == 28'd0) ? 34'd0 :
                  (w_ef > 10'sd255) ? {2'b10, w_a[31], 31'd0} :
                  (w_ef < 10'sd0)   ? {2'b00, w_a[31], 31'd0} :
                  {2'b01, w_a[31], w_ef[7:0], w_rnd[24] ? w_rnd[23:1] : w_rnd[22:0]};
  assign w_res = (w_xe == 2'b11 || w_ye == 2'b11 ||
                  (w_xe == 2'b10 && w_ye == 2'b10 && w_x[31] != w_y[31])) ? 34'h300000000 :
                 (w_xe == 2'b10) ? {2'b10, w_x[31], 31'd0} :
                 (w_ye == 2'b10) ? {2'b10, w_y[31], 31'd0} :
                 (w_xe == 2'b00 && w_ye == 2'b00) ? {2'b00, w_x[31] & w_y[31], 31'd0} :
                 (w_xe == 2'b00) ? w_y :
                 (w_ye == 2'b00) ? w_x : w_norm;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_r <= 34'd0;
      r_v <= 1'b0;
    end else begin
      r_r <= w_res;
      r_v <= w_v;
    end
  end
  assign R         = r_r;
  assign out_valid = r_v;
endmodule

// File: tb/tb_fp32_adder.sv
// tb_fp32_adder: directed vector table, reset sequences and random pairs against an exact-arithmetic model.
module tb_fp32_adder;
`ifdef FP32_ADDER_INPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [33:0] X = 34'd0;
  logic [33:0] Y = 34'd0;
  logic [33:0] R;
  logic        out_valid;
  int n_vec = 0;
  int n_err = 0;
  logic        pv[$];
  logic [33:0] pe[$];
  string       pn[$];

  typedef struct {
    logic [33:0] x;
    logic [33:0] y;
    logic [33:0] r;
    string       nm;
  } vec_t;

  fp32_adder dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .X(X), .Y(Y), .R(R), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  // Exact sum as a wide integer in units of 2^-150, then a single RNE rounding.
  function automatic logic [33:0] ref_add(input logic [33:0] x, input logic [33:0] y);
    logic [299:0] na, nb, n, q, rem, half;
    logic [1:0] xe, ye;
    logic s;
    int p, e;
    xe = x[33:32];
    ye = y[33:32];
    if (xe == 2'b11 || ye == 2'b11 || (xe == 2'b10 && ye == 2'b10 && x[31] != y[31])) return 34'h300000000;
    if (xe == 2'b10) return {2'b10, x[31], 31'd0};
    if (ye == 2'b10) return {2'b10, y[31], 31'd0};
    if (xe == 2'b00 && ye == 2'b00) return {2'b00, x[31] & y[31], 31'd0};
    if (xe == 2'b00) return y;
    if (ye == 2'b00) return x;
    na = 300'({1'b1, x[22:0]}) << x[30:23];
    nb = 300'({1'b1, y[22:0]}) << y[30:23];
    if (x[31] == y[31]) begin n = na + nb; s = x[31]; end
    else if (na >= nb) begin n = na - nb; s = x[31]; end
    else begin n = nb - na; s = y[31]; end
    if (n == 300'd0) return 34'd0;
    p = -1;
    for (int i = 0; i < 300; i++) if (n[i]) p = i;
    e = p - 23;
    if (e > 0) begin
      q = n >> e;
      rem = n & ((300'd1 << e) - 300'd1);
      half = 300'd1 << (e - 1);
      if (rem > half || (rem == half && q[0])) q = q + 300'd1;
    end else q = n << (-e);
    if (q[24]) begin q = q >> 1; e++; end
    if (e > 255) return {2'b10, s, 31'd0};
    if (e < 0) return {2'b00, s, 31'd0};
    return {2'b01, s, e[7:0], q[22:0]};
  endfunction

  task automatic chk(input string nm, input logic [33:0] act, input logic [33:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  task automatic step(input logic v, input logic [33:0] x, input logic [33:0] y,
                      input logic [33:0] e, input string nm);
    logic ev;
    logic [33:0] er;
    string en;
    @(negedge clk);
    in_valid = v;
    X = x;
    Y = y;
    pv.push_back(v);
    pe.push_back(e);
    pn.push_back(nm);
    @(posedge clk);
    #1;
    if (pv.size() == LAT) begin
      ev = pv.pop_front();
      er = pe.pop_front();
      en = pn.pop_front();
      chk({en, "_valid"}, {33'd0, out_valid}, {33'd0, ev});
      if (ev) chk(en, R, er);
    end
  endtask

  vec_t tbl[$];

  initial begin
    tbl.push_back('{34'h13f000000, 34'h13f800000, 34'h13fc00000, "half_plus_one"});
    tbl.push_back('{34'h140400000, 34'h13f000000, 34'h140600000, "three_plus_half"});
    tbl.push_back('{34'h1c0000000, 34'h1c0200000, 34'h1c0900000, "neg_sum"});
    tbl.push_back('{34'h100000000, 34'h140a00000, 34'h140a00000, "tiny_plus_five"});
    tbl.push_back('{34'h13f800000, 34'h1bf800000, 34'h000000000, "cancel"});
    tbl.push_back('{34'h200000000, 34'h280000000, 34'h300000000, "inf_minus_inf"});
    tbl.push_back('{34'h200000000, 34'h140400000, 34'h200000000, "pinf_plus_norm"});
    tbl.push_back('{34'h1c0000000, 34'h280000000, 34'h280000000, "norm_plus_ninf"});
    tbl.push_back('{34'h280000000, 34'h280000000, 34'h280000000, "ninf_plus_ninf"});
    tbl.push_back('{34'h300000000, 34'h13f800000, 34'h300000000, "nan_plus_norm"});
    tbl.push_back('{34'h13f800000, 34'h3c0000000, 34'h300000000, "norm_plus_nan"});
    tbl.push_back('{34'h13f800000, 34'h133800000, 34'h13f800000, "tie_even_down"});
    tbl.push_back('{34'h13f800001, 34'h133800000, 34'h13f800002, "tie_odd_up"});
    tbl.push_back('{34'h17fffffff, 34'h17fffffff, 34'h200000000, "overflow_inf"});
    tbl.push_back('{34'h080000000, 34'h080000000, 34'h080000000, "nzero_nzero"});
    tbl.push_back('{34'h000000000, 34'h080000000, 34'h000000000, "pzero_nzero"});
    tbl.push_back('{34'h080000000, 34'h1c0a00000, 34'h1c0a00000, "zero_plus_norm"});
    tbl.push_back('{34'h180400000, 34'h100000000, 34'h080000000, "flush_neg"});
    tbl.push_back('{34'h1bf800000, 34'h13f800000, 34'h000000000, "cancel_swap"});

    repeat (2) @(posedge clk);
    #1;
    chk("reset_R", R, 34'd0);
    chk("reset_valid", {33'd0, out_valid}, 34'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_release_R", R, 34'd0);

    foreach (tbl[i]) step(1'b1, tbl[i].x, tbl[i].y, tbl[i].r, tbl[i].nm);
    step(1'b0, 34'd0, 34'd0, 34'd0, "idle");

    step(1'b1, 34'h13f000000, 34'h13f800000, 34'h13fc00000, "pre_reset");
    @(negedge clk);
    in_valid = 1'b1;
    X = 34'h140400000;
    Y = 34'h13f000000;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_R", R, 34'd0);
    chk("midreset_valid", {33'd0, out_valid}, 34'd0);
    @(posedge clk);
    #1;
    chk("midreset_hold_R", R, 34'd0);
    chk("midreset_hold_valid", {33'd0, out_valid}, 34'd0);
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
    pv.delete();
    pe.delete();
    pn.delete();
    #1;
    chk("release_R", R, 34'd0);

    for (int i = 0; i < 1500; i++) begin
      logic [31:0] r1, r2;
      logic [33:0] a, b;
      logic v;
      int k;
      r1 = $urandom;
      r2 = $urandom;
      k = $urandom_range(0, 15);
      a = {2'b01, r1};
      b = {2'b01, r2};
      if (k < 6) begin
        b[30:23] = a[30:23] + 8'($urandom_range(0, 2));
        if (k < 3) b[22:0] = a[22:0] ^ 23'($urandom_range(0, 15));
      end else if (k == 6) b[33:32] = 2'b11;
      else if (k == 7) b[33:32] = 2'b10;
      else if (k == 8) b[33:32] = 2'b00;
      else if (k == 9) begin
        a[30:23] = 8'hff;
        b[30:23] = 8'(8'hff - 8'($urandom_range(0, 3)));
        b[31] = a[31];
      end else if (k == 10) begin
        a[30:23] = 8'd0;
        b[30:23] = 8'($urandom_range(0, 2));
      end
      v = ($urandom_range(0, 3) != 0);
      step(v, a, b, ref_add(a, b), "rand");
      step(1'b1, b, a, ref_add(b, a), "rand_swap");
    end
    step(1'b0, 34'd0, 34'd0, 34'd0, "drain");
    step(1'b0, 34'd0, 34'd0, 34'd0, "drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
